// File: rtl/btn_pkg.sv
// Shared types for the push-button conditioner: channel states and button indices.
// Pure declarations, no logic; imported by the channel and the top.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } chanState_t;

    localparam int BTN_C   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_R   = 2;
    localparam int BTN_U   = 3;
    localparam int BTN_D   = 4;
    localparam int NUM_BTN = 5;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchronizer, debounce FSM, optional auto-repeat (BTN_AUTOREPEAT_EN).
// Latency: raw level stable from cycle t changes debounced at t+2+DEBOUNCE_CYCLES.
// Backpressure: none; press is a registered one-cycle pulse.
module btn_debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic rawBtn,
    output logic debounced,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_RATE < 1))) begin : gBadCfg
        $error("btn_debounce_channel: cycle counts must be at least 1");
    end

    logic          sync1;
    logic          syncBtn;
    chanState_t    state;
    logic [CW-1:0] cnt;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(maxInt(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] repCnt;
    logic          repFirstDone;
`endif

    // cnt holds the number of further agreeing cycles seen since entering a CHK state;
    // the cycle that caused the entry counts as the first one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1        <= 1'b0;
            syncBtn      <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            debounced    <= 1'b0;
            press        <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            repCnt       <= '0;
            repFirstDone <= 1'b0;
`endif
        end else begin
            sync1   <= rawBtn;
            syncBtn <= sync1;
            press   <= 1'b0;
            case (state)
                IDLE: begin
                    if (syncBtn) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!syncBtn) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= HELD;
                        cnt       <= '0;
                        debounced <= 1'b1;
                        press     <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        repCnt       <= '0;
                        repFirstDone <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!syncBtn) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (REPEAT_EN) begin
                        if (repCnt == (repFirstDone ? RATE_LAST : DELAY_LAST)) begin
                            press        <= 1'b1;
                            repCnt       <= '0;
                            repFirstDone <= 1'b1;
                        end else begin
                            repCnt <= repCnt + 1'b1;
                        end
                    end
`endif
                end
                RELEASE_CHK: begin
                    if (syncBtn) begin
                        state <= HELD;
                        cnt   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                        repCnt       <= '0;
                        repFirstDone <= 1'b0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        debounced <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Five-button debouncer with press pulses; auto-repeat on L/R/U/D under BTN_AUTOREPEAT_EN.
// Latency: DEBOUNCE_CYCLES+2 from a stable raw level to debounced level and press pulse.
// Backpressure: none; outputs are registered levels and one-cycle pulses.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnC,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnU,
    input  logic       btnD,
    output logic       btnC_debounced,
    output logic       btnL_debounced,
    output logic       btnR_debounced,
    output logic       btnU_debounced,
    output logic       btnD_debounced,
    output logic [4:0] btn_press
);

    logic [NUM_BTN-1:0] rawBtn;
    logic [NUM_BTN-1:0] debounced;

    assign rawBtn[BTN_C] = btnC;
    assign rawBtn[BTN_L] = btnL;
    assign rawBtn[BTN_R] = btnR;
    assign rawBtn[BTN_U] = btnU;
    assign rawBtn[BTN_D] = btnD;

    // The centre button is a select key and never auto-repeats.
    for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .REPEAT_EN       (i != BTN_C)
        ) uChan (
            .clk       (clk),
            .reset     (reset),
            .rawBtn    (rawBtn[i]),
            .debounced (debounced[i]),
            .press     (btn_press[i])
        );
    end

    assign btnC_debounced = debounced[BTN_C];
    assign btnL_debounced = debounced[BTN_L];
    assign btnR_debounced = debounced[BTN_R];
    assign btnU_debounced = debounced[BTN_U];
    assign btnD_debounced = debounced[BTN_D];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed scenarios plus random button activity, checked every cycle against a run-length model.
module tb_button_conditioner;

    localparam int N = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam int D = 20;
    localparam int R = 5;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       btnC, btnL, btnR, btnU, btnD;
    logic       btnC_debounced, btnL_debounced, btnR_debounced, btnU_debounced, btnD_debounced;
    logic [4:0] btn_press;

    button_conditioner #(
        .DEBOUNCE_CYCLES (8),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btnC           (btnC),
        .btnL           (btnL),
        .btnR           (btnR),
        .btnU           (btnU),
        .btnD           (btnD),
        .btnC_debounced (btnC_debounced),
        .btnL_debounced (btnL_debounced),
        .btnR_debounced (btnR_debounced),
        .btnU_debounced (btnU_debounced),
        .btnD_debounced (btnD_debounced),
        .btn_press      (btn_press)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    // Reference model: per button, the synchronized sample stream and its current run.
    bit hist[5][$];
    bit mDeb[5];
    bit mPress[5];
    bit runVal[5];
    int runLen[5];
    bit prevSeen[5];
    bit active[5];
    int age[5];

    // Observations of the DUT for directed scenario checks.
    int         pressCnt[5];
    int         lastPress[5];
    int         riseAt[5];
    int         fallAt[5];
    logic [4:0] prevDebObs;

    function automatic logic [4:0] rawVec();
        return {btnD, btnU, btnR, btnL, btnC};
    endfunction

    function automatic logic [4:0] debVec();
        return {btnD_debounced, btnU_debounced, btnR_debounced, btnL_debounced, btnC_debounced};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        assert (got === exp) else begin
            nFail++;
            $error("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < 5; b++) begin
            hist[b].delete();
            mDeb[b]     = 1'b0;
            mPress[b]   = 1'b0;
            runVal[b]   = 1'b0;
            runLen[b]   = 0;
            prevSeen[b] = 1'b0;
            active[b]   = 1'b0;
            age[b]      = 0;
        end
    endtask

    // A level is accepted once N+1 consecutive synchronized samples disagree with the current level.
    task automatic modelStep();
        logic [4:0] raw;
        bit seen, rose, rep;
        raw = rawVec();
        for (int b = 0; b < 5; b++) begin
            hist[b].push_back(raw[b]);
            if (hist[b].size() > 3) void'(hist[b].pop_front());
            seen = (hist[b].size() == 3) ? hist[b][0] : 1'b0;
            if (seen == runVal[b]) runLen[b]++;
            else begin
                runVal[b] = seen;
                runLen[b] = 1;
            end
            rose = 1'b0;
            rep  = 1'b0;
            if (runVal[b] != mDeb[b] && runLen[b] >= N + 1) begin
                mDeb[b] = runVal[b];
                rose    = runVal[b];
            end
`ifdef BTN_AUTOREPEAT_EN
            if (b != 0) begin
                if (rose) begin
                    active[b] = 1'b1;
                    age[b]    = 0;
                end else if (mDeb[b] && seen) begin
                    if (!prevSeen[b]) begin
                        active[b] = 1'b1;
                        age[b]    = 0;
                    end else if (active[b]) begin
                        age[b]++;
                        if (age[b] == D || (age[b] > D && (age[b] - D) % R == 0)) rep = 1'b1;
                    end
                end else begin
                    active[b] = 1'b0;
                end
            end
`endif
            mPress[b]   = rose | rep;
            prevSeen[b] = seen;
        end
    endtask

    task automatic observe();
        logic [4:0] dv;
        dv = debVec();
        for (int b = 0; b < 5; b++) begin
            if (btn_press[b]) begin
                pressCnt[b]++;
                lastPress[b] = cyc;
            end
            if (dv[b] && !prevDebObs[b]) riseAt[b] = cyc;
            if (!dv[b] && prevDebObs[b]) fallAt[b] = cyc;
        end
        prevDebObs = dv;
    endtask

    task automatic tick();
        logic [4:0] md, mp;
        @(posedge clk);
        if (!reset) modelReset();
        else modelStep();
        cyc++;
        #1;
        for (int b = 0; b < 5; b++) begin
            md[b] = mDeb[b];
            mp[b] = mPress[b];
        end
        chk("debounced", 32'(debVec()), 32'(md));
        chk("btn_press", 32'(btn_press), 32'(mp));
        observe();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int e;
        int relE;
        int uHigh;
        logic minC;
        int expR;
        int holdLeft[5];
        logic [4:0] rv;

        reset = 1'b0;
        {btnD, btnU, btnR, btnL, btnC} = 5'b0;
        prevDebObs = 5'b0;
        for (int b = 0; b < 5; b++) begin
            pressCnt[b] = 0; lastPress[b] = -1; riseAt[b] = -1; fallAt[b] = -1; holdLeft[b] = 0;
        end
        modelReset();
        ticks(3);
        reset = 1'b1;
        ticks(12);

        // Clean press of R
        btnR = 1'b1;
        e = cyc + 1;
        pressCnt[2] = 0;
        ticks(15);
        chk("R rise edge", riseAt[2], e + N + 2);
        chk("R press edge", lastPress[2], e + N + 2);
        chk("R press count", pressCnt[2], 1);
        btnR = 1'b0;
        ticks(14);

        // Bounce on U shorter than the debounce window
        pressCnt[3] = 0;
        uHigh = 0;
        for (int i = 0; i < 30; i++) begin
            btnU = ((i / 3) % 2 == 0);
            tick();
            if (btnU_debounced) uHigh++;
        end
        btnU = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (btnU_debounced) uHigh++;
        end
        chk("U bounce pulses", pressCnt[3], 0);
        chk("U bounce level", uHigh, 0);

        // Release of C after a 40-cycle hold, then a short release glitch
        btnC = 1'b1;
        pressCnt[0] = 0;
        ticks(40);
        btnC = 1'b0;
        relE = cyc + 1;
        ticks(14);
        chk("C fall edge", fallAt[0], relE + N + 2);
        chk("C release press count", pressCnt[0], 1);
        btnC = 1'b1;
        ticks(14);
        minC = 1'b1;
        btnC = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            minC &= btnC_debounced;
        end
        btnC = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            minC &= btnC_debounced;
        end
        chk("C glitch level", minC, 1);
        chk("C glitch press count", pressCnt[0], 2);
        btnC = 1'b0;
        ticks(14);

        // Simultaneous L and D
        btnL = 1'b1;
        btnD = 1'b1;
        ticks(N + 3);
        chk("simultaneous press", btn_press, 5'b10010);
        tick();
        chk("simultaneous pulse width", btn_press, 5'b00000);
        btnL = 1'b0;
        btnD = 1'b0;
        ticks(14);

        // Reset during PRESS_CHK with L held, then a fresh press after release
        btnL = 1'b1;
        ticks(3 + 5);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        chk("async reset debounced", debVec(), 5'b00000);
        chk("async reset btn_press", btn_press, 5'b00000);
        prevDebObs = debVec();
        ticks(3);
        reset = 1'b1;
        pressCnt[1] = 0;
        e = cyc + 1;
        ticks(N + 3);
        chk("L press after reset", lastPress[1], e + N + 2);
        chk("L press count after reset", pressCnt[1], 1);
        btnL = 1'b0;
        ticks(14);

        // Long holds: R repeats when enabled, C never does
`ifdef BTN_AUTOREPEAT_EN
        expR = 8;
`else
        expR = 1;
`endif
        btnR = 1'b1;
        pressCnt[2] = 0;
        ticks(60);
        btnR = 1'b0;
        ticks(14);
        chk("R hold pulses", pressCnt[2], expR);
        btnC = 1'b1;
        pressCnt[0] = 0;
        ticks(60);
        btnC = 1'b0;
        ticks(14);
        chk("C hold pulses", pressCnt[0], 1);

        // Random activity, alternating bouncy and steady phases, with one reset in the middle
        rv = 5'b0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 5; b++) begin
                if (holdLeft[b] == 0) begin
                    rv[b] = 1'($urandom_range(0, 1));
                    holdLeft[b] = (i % 300 < 150) ? int'($urandom_range(1, 6)) : int'($urandom_range(6, 40));
                end else begin
                    holdLeft[b]--;
                end
            end
            {btnD, btnU, btnR, btnL, btnC} = rv;
            if (i == 700) reset = 1'b0;
            if (i == 703) reset = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
